// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and small op-classification helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator: val_o = neg_i ? -val_i : val_i.
// Purely combinational.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_o
);

    always_comb begin
        val_o = val_i;
        if (neg_i) begin
            val_o = ~val_i + W'(1);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide
// on a shared 2*XLEN shift register. MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] srca_i,
    input  logic [XLEN-1:0] srcb_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Operand magnitudes and result sign, evaluated at accept
    logic                a_neg, b_neg, b_zero, res_neg;
    logic [XLEN-1:0]     a_mag, b_mag;

    assign a_neg  = a_is_signed(funct3_i) & srca_i[XLEN-1];
    assign b_neg  = b_is_signed(funct3_i) & srcb_i[XLEN-1];
    assign b_zero = (srcb_i == '0);

    muldiv_negate #(.W(XLEN)) u_neg_a (.neg_i(a_neg), .val_i(srca_i), .val_o(a_mag));
    muldiv_negate #(.W(XLEN)) u_neg_b (.neg_i(b_neg), .val_i(srcb_i), .val_o(b_mag));

    // Divide-by-zero quotient must stay all-ones, so suppress its sign fix-up
    always_comb begin
        res_neg = a_neg ^ b_neg;
        if ((funct3_i == F3_DIV) || (funct3_i == F3_DIVU)) begin
            res_neg = (a_neg ^ b_neg) & ~b_zero;
        end else if ((funct3_i == F3_REM) || (funct3_i == F3_REMU)) begin
            res_neg = a_neg;
        end
    end

    // One iteration of either algorithm on the shared accumulator
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_sh;
    logic [XLEN:0]       div_diff;
    logic                q_bit;
    logic [2*XLEN-1:0]   mul_step, div_step, step;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]};
        if (acc_q[0]) begin
            mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        end
        mul_step = {mul_sum, acc_q[XLEN-1:1]};

        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = rem_sh - {1'b0, opnd_q};
        q_bit    = ~div_diff[XLEN];
        div_step = {(q_bit ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                    acc_q[XLEN-2:0], q_bit};

        step = is_div_op(op_q) ? div_step : mul_step;
    end

    // Final sign fix-up spans the full product so MULH* see a correct high half
    logic [2*XLEN-1:0]   fix_in, fix_out;
    logic [XLEN-1:0]     final_res;

    always_comb begin
        fix_in = step;
        if (is_div_op(op_q)) begin
            fix_in = op_q[1] ? {{XLEN{1'b0}}, step[2*XLEN-1:XLEN]}
                             : {{XLEN{1'b0}}, step[XLEN-1:0]};
        end
    end

    muldiv_negate #(.W(2*XLEN)) u_neg_res (.neg_i(neg_q), .val_i(fix_in), .val_o(fix_out));

    assign final_res = ((op_q == F3_MUL) || is_div_op(op_q)) ? fix_out[XLEN-1:0]
                                                             : fix_out[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]   fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]     fast_res;

    always_comb begin
        fast_a    = {{XLEN{a_neg}}, srca_i};
        fast_b    = {{XLEN{b_neg}}, srcb_i};
        fast_prod = fast_a * fast_b;
        fast_res  = (funct3_i == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    logic accept;
    assign accept = start_i && !flush_i;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = ST_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        result_d = final_res;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (accept) begin
                    state_d = ST_BUSY;
                    busy_d  = 1'b1;
                    op_d    = funct3_i;
                    neg_d   = res_neg;
                    cnt_d   = CNT_W'(XLEN);
                    if (is_div_op(funct3_i)) begin
                        opnd_d = b_mag;
                        acc_d  = {{XLEN{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{XLEN{1'b0}}, b_mag};
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (!is_div_op(funct3_i)) begin
                        state_d  = ST_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        cnt_d    = '0;
                        result_d = fast_res;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M vectors, randomized ops against an
// arithmetic reference model, flush/reset abort and back-to-back sequencing.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start_i = 1'b0;
    logic [2:0]      funct3_i = 3'b000;
    logic [XLEN-1:0] srca_i = '0;
    logic [XLEN-1:0] srcb_i = '0;
    logic            flush_i = 1'b0;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int tests_run = 0;
    int fails = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .funct3_i(funct3_i),
        .srca_i(srca_i), .srcb_i(srcb_i), .flush_i(flush_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    // Reference model straight from the RV32M definitions using 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint    sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'b000: begin p = 64'(sa * sb); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = 64'(ua / ub); return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = 64'(ua % ub); return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3);
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Present one request for a single cycle; afterwards the operand buses are scrambled
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; srca_i = a; srcb_i = b;
        @(negedge clk);
        start_i = 1'b0; funct3_i = 3'($urandom); srca_i = $urandom; srcb_i = $urandom;
    endtask

    // Called in cycle 1 after accept; returns cycle of done_o (-1 on timeout)
    task automatic wait_done(output int lat, output int busy_cnt, output logic [31:0] res);
        lat = 1; busy_cnt = 0;
        while (done_o !== 1'b1 && lat < 200) begin
            busy_cnt += (busy_o === 1'b1) ? 1 : 0;
            @(negedge clk);
            lat++;
        end
        if (done_o !== 1'b1) lat = -1;
        res = result_o;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b result=%h, required 0 0 00000000",
                     busy_o, done_o, result_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s  [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                   3'd4, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] as   [14] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                   32'd5, 32'h1234, 32'h80000000, 32'h80000000,
                                   32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] bs   [14] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] exps [14] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                   32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                   32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0,
                                   32'hFFFFFFFF, 32'hFFFFFFFB};
        int lat, bc;
        logic [31:0] res;
        for (int i = 0; i < 14; i++) begin
            issue(f3s[i], as[i], bs[i]);
            wait_done(lat, bc, res);
            tests_run++;
            if (res !== exps[i]) begin
                fails++;
                $display("FAIL directed[%0d] result: got %h, required %h", i, res, exps[i]);
            end
            tests_run++;
            if (lat !== exp_latency(f3s[i]) || bc !== exp_latency(f3s[i]) - 1) begin
                fails++;
                $display("FAIL directed[%0d] timing: done cycle %0d busy cycles %0d, required %0d and %0d",
                         i, lat, bc, exp_latency(f3s[i]), exp_latency(f3s[i]) - 1);
            end
        end
    endtask

    task automatic test_random(input bit div_ops, input int n);
        logic [2:0]  f3;
        logic [31:0] a, b, res;
        int lat, bc;
        for (int i = 0; i < n; i++) begin
            f3 = {div_ops, 2'($urandom)};
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = 32'($urandom_range(0, 300));
                default: ;
            endcase
            issue(f3, a, b);
            wait_done(lat, bc, res);
            tests_run++;
            if (res !== ref_model(f3, a, b) || lat !== exp_latency(f3)) begin
                fails++;
                $display("FAIL random f3=%0d a=%h b=%h: got %h at cycle %0d, required %h at cycle %0d",
                         f3, a, b, res, lat, ref_model(f3, a, b), exp_latency(f3));
            end
        end
    endtask

    // Abort a DIV in cycle 10 via flush (use_reset=0) or reset (use_reset=1)
    task automatic test_abort(input bit use_reset);
        int lat, bc, dones;
        logic [31:0] res, prev;
        issue(3'b101, 32'd100, 32'd7);
        wait_done(lat, bc, prev);
        issue(3'b100, 32'hFFFFF000, 32'd3);
        repeat (9) @(negedge clk);
        if (use_reset) reset = 1'b1; else flush_i = 1'b1;
        @(negedge clk);
        reset = 1'b0; flush_i = 1'b0;
        tests_run++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL abort(reset=%0d) idle: busy=%b done=%b, required 0 0", use_reset, busy_o, done_o);
        end
        dones = 0;
        for (int c = 0; c < 45; c++) begin
            dones += (done_o === 1'b1) ? 1 : 0;
            @(negedge clk);
        end
        tests_run++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL abort(reset=%0d) done pulses: got %0d, required 0", use_reset, dones);
        end
        res = use_reset ? 32'h0 : prev;
        tests_run++;
        if (result_o !== res) begin
            fails++;
            $display("FAIL abort(reset=%0d) result: got %h, required %h", use_reset, result_o, res);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, dones;
        logic [31:0] res, first_res;
        issue(3'b101, 32'd1000, 32'd9);
        wait_done(lat, bc, first_res);
        // start_i held across the DONE cycle must be accepted with no idle gap
        start_i = 1'b1; funct3_i = 3'b110; srca_i = 32'hFFFFFF9C; srcb_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        tests_run++;
        if (first_res !== 32'd111 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back accept: first=%h busy=%b done=%b, required 0000006f 1 0",
                     first_res, busy_o, done_o);
        end
        wait_done(lat, bc, res);
        tests_run++;
        if (res !== ref_model(3'b110, 32'hFFFFFF9C, 32'd7) || lat !== XLEN + 1) begin
            fails++;
            $display("FAIL back_to_back second: got %h at cycle %0d, required %h at cycle %0d",
                     res, lat, ref_model(3'b110, 32'hFFFFFF9C, 32'd7), XLEN + 1);
        end
        // start_i pulsed while busy must be ignored
        issue(3'b101, 32'd5000, 32'd3);
        repeat (4) @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b100; srca_i = 32'd77; srcb_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0;
        dones = 0; res = 32'h0;
        for (int c = 0; c < 80; c++) begin
            if (done_o === 1'b1) begin dones++; res = result_o; end
            @(negedge clk);
        end
        tests_run++;
        if (dones !== 1 || res !== 32'd1666) begin
            fails++;
            $display("FAIL busy_start_ignored: %0d done pulses result %h, required 1 and 00000682",
                     dones, res);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(1'b0, 25);
        test_random(1'b1, 25);
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
